keypad_event_decoder: RTL

Consumer-side partner of the 4x4 keypad row scanner. Takes the four per-row column snapshots the scanner publishes, debounces all 16 keys, detects press and release edges, and delivers them as 5-bit key events through a small FIFO with a valid/ready handshake. Sits between the keypad scanner and game/control logic, so downstream blocks see single clean events instead of raw level snapshots.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_event_fifo.sv | 60 ++++++
 rtl/keypad_event_decoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_pkg : shared keypad key-code and event-format constants        |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package keypad_pkg;

   localparam int KEY_COUNT     = 16;
   localparam int KEY_CODE_W    = 4;
   localparam int EVT_W         = 5;
   localparam int EVT_PRESS_BIT = 4;
   localparam int EVT_CODE_HI   = 3;
   localparam int EVT_CODE_LO   = 0;
   localparam int ROWS          = 4;
   localparam int COLS          = 4;

   function automatic logic [KEY_CODE_W-1:0] key_code(input int row, input int col);
      return KEY_CODE_W'(COLS * row + col);
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_event_fifo : synchronous show-ahead FIFO, head is 0 when empty |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module keypad_event_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   assign full   = (r_count == CNT_W'(DEPTH));
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign head   = empty ? '0 : r_mem[r_rd_ptr];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/keypad_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_event_decoder : debounces 16 keys, queues press/release events |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module keypad_event_decoder
   import keypad_pkg::*;
#(
   parameter int SAMPLE_CYCLES    = 2000004,
   parameter int DEBOUNCE_SAMPLES = 3,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [COLS-1:0]      rowState0,
   input  logic [COLS-1:0]      rowState1,
   input  logic [COLS-1:0]      rowState2,
   input  logic [COLS-1:0]      rowState3,
   output logic                 evt_valid,
   output logic [EVT_W-1:0]     evt_data,
   input  logic                 evt_ready,
   output logic [KEY_COUNT-1:0] key_state,
   output logic                 any_pressed,
   output logic                 overflow,
   input  logic                 clr_overflow
);

   localparam int         SAMPLE_W   = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam int         FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [4:0] DB_LIMIT   = 5'(DEBOUNCE_SAMPLES);

   logic [SAMPLE_W-1:0]   r_sample_cnt;
   logic                  w_tick;
   logic [COLS-1:0]       w_rows [ROWS];
   logic [KEY_COUNT-1:0]  w_raw;
   logic [3:0]            r_db_cnt [KEY_COUNT];
   logic [3:0]            w_db_nxt [KEY_COUNT];
   logic [KEY_COUNT-1:0]  w_flip;
   logic [KEY_COUNT-1:0]  r_key_state;
   logic [KEY_COUNT-1:0]  r_pending;
   logic [KEY_COUNT-1:0]  w_pending_nxt;
   logic [KEY_COUNT-1:0]  w_cancel;
   logic [KEY_COUNT-1:0]  w_clear;
   logic [KEY_CODE_W-1:0] w_sel;
   logic                  w_push;
   logic [EVT_W-1:0]      w_push_data;
   logic                  r_overflow;
   logic                  w_pop;
   logic [EVT_W-1:0]      w_fifo_head;
   logic [FIFO_CNT_W-1:0] w_fifo_count;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic                  w_fifo_count_unused;

   assign w_tick = (r_sample_cnt == SAMPLE_W'(SAMPLE_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_sample_cnt <= '0;
      else if (w_tick) r_sample_cnt <= '0;
      else             r_sample_cnt <= r_sample_cnt + SAMPLE_W'(1);
   end

   assign w_rows[0] = rowState0;
   assign w_rows[1] = rowState1;
   assign w_rows[2] = rowState2;
   assign w_rows[3] = rowState3;

   always_comb begin
      w_raw = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            w_raw[key_code(r, c)] = w_rows[r][c];
         end
      end
   end

   always_comb begin
      w_flip = '0;
      for (int k = 0; k < KEY_COUNT; k++) begin
         w_db_nxt[k] = r_db_cnt[k];
         if (w_tick) begin
            if (w_raw[k] == r_key_state[k]) begin
               w_db_nxt[k] = '0;
            end else if (({1'b0, r_db_cnt[k]} + 5'd1) == DB_LIMIT) begin
               w_flip[k]   = 1'b1;
               w_db_nxt[k] = '0;
            end else begin
               w_db_nxt[k] = r_db_cnt[k] + 4'd1;
            end
         end
      end
   end

   // Lowest pending code wins the single push slot each cycle.
   always_comb begin
      w_sel = '0;
      for (int k = KEY_COUNT - 1; k >= 0; k--) begin
         if (r_pending[k]) w_sel = KEY_CODE_W'(k);
      end
   end

   assign w_push  = (|r_pending) & ~w_fifo_full;
   assign w_clear = w_push ? (KEY_COUNT'(1) << w_sel) : '0;

   always_comb begin
      w_push_data                          = '0;
      w_push_data[EVT_PRESS_BIT]           = r_key_state[w_sel];
      w_push_data[EVT_CODE_HI:EVT_CODE_LO] = w_sel;
   end

   // A flip on an unsent event cancels the pair; a flip racing its own push queues anew.
   always_comb begin
      w_pending_nxt = '0;
      w_cancel      = '0;
      for (int k = 0; k < KEY_COUNT; k++) begin
         if (w_flip[k]) begin
            w_pending_nxt[k] = w_clear[k] | ~r_pending[k];
            w_cancel[k]      = r_pending[k] & ~w_clear[k];
         end else begin
            w_pending_nxt[k] = r_pending[k] & ~w_clear[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key_state <= '0;
         r_pending   <= '0;
         r_overflow  <= 1'b0;
         for (int k = 0; k < KEY_COUNT; k++) r_db_cnt[k] <= '0;
      end else begin
         r_key_state <= r_key_state ^ w_flip;
         r_pending   <= w_pending_nxt;
         for (int k = 0; k < KEY_COUNT; k++) r_db_cnt[k] <= w_db_nxt[k];
         if (|w_cancel)         r_overflow <= 1'b1;
         else if (clr_overflow) r_overflow <= 1'b0;
      end
   end

   keypad_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_fifo_head),
      .count     (w_fifo_count),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty)
   );

   assign w_fifo_count_unused = |w_fifo_count;

   assign evt_valid   = ~w_fifo_empty;
   assign evt_data    = w_fifo_head;
   assign w_pop       = evt_valid & evt_ready;
   assign key_state   = r_key_state;
   assign any_pressed = |r_key_state;
   assign overflow    = r_overflow;

endmodule
`default_nettype wire
